fe_redirect_ctl: RTL and testbench



---
 rtl/fe_pkg.sv | 33 +++
 rtl/fe_branch_decode.sv | 28 ++
 rtl/fe_redirect_ctl.sv | 155 +++++++++++++++
 tb/tb_fe_redirect_ctl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared front-end definitions: redirect/stall encodings, opcodes and the
// sequencer state type used by the decode-side redirect controller.
package fe_pkg;

    // Redirect kind presented to the fetch stage
    localparam logic [1:0] JT_SEQ = 2'b00;
    localparam logic [1:0] JT_REG = 2'b01;
    localparam logic [1:0] JT_IMM = 2'b10;
    localparam logic [1:0] JT_INT = 2'b11;

    // Fetch PC control
    localparam logic [1:0] CTR_RUN   = 2'b00;
    localparam logic [1:0] CTR_STALL = 2'b10;

    // Control-flow opcodes (isn[31:26])
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JR   = 6'h03;
    localparam logic [5:0] OPC_TRAP = 6'h3F;

    // Fetch restarts here on an interrupt or trap
    localparam logic [31:0] IRQ_VECTOR = 32'hC000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } fe_state_e;

    // Word offset of a PC-relative jump, sign-extended to a byte offset
    function automatic logic [31:0] j_offset(input logic [25:0] imm);
        return {{4{imm[25]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fe_branch_decode.sv
// Pure combinational decode of the held instruction's control-flow opcode
// and the PC-relative jump target.
module fe_branch_decode
    import fe_pkg::*;
#(
    parameter logic [5:0] OP_J    = OPC_J,
    parameter logic [5:0] OP_JR   = OPC_JR,
    parameter logic [5:0] OP_TRAP = OPC_TRAP
) (
    input  logic [31:0] isn,
    input  logic [31:0] n_pc,
    output logic        is_j,
    output logic        is_jr,
    output logic        is_trap,
    output logic [31:0] jmp_i
);

    logic [5:0] opcode_s;

    assign opcode_s = isn[31:26];
    assign is_j     = (opcode_s == OP_J);
    assign is_jr    = (opcode_s == OP_JR);
    assign is_trap  = (opcode_s == OP_TRAP);

    // Target is relative to the already-incremented PC; wraps mod 2^32
    assign jmp_i = n_pc + j_offset(isn[25:0]);

endmodule

// File: rtl/fe_redirect_ctl.sv
// Decode-side redirect controller: holds the fetched instruction, stalls
// fetch on backpressure or an unresolved JR source, raises redirects, and
// squashes the wrong-path fetches that follow each redirect.
module fe_redirect_ctl
    import fe_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 1,
    parameter logic [5:0]  OP_J          = OPC_J,
    parameter logic [5:0]  OP_JR         = OPC_JR,
    parameter logic [5:0]  OP_TRAP       = OPC_TRAP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] n_pc,
    input  logic [31:0] isn,
    output logic [1:0]  ctr,
    output logic [1:0]  jmp_type,
    output logic [31:0] jmp_r,
    output logic [31:0] jmp_i,
    input  logic [31:0] rs_data,
    input  logic        rs_busy,
    input  logic        irq_req,
    output logic        irq_ack,
    output logic        de_valid,
    input  logic        de_ready,
    output logic [31:0] de_isn,
    output logic [31:0] de_pc
);

    localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES);

    logic        valid_q;
    logic [31:0] isn_q;
    logic [31:0] n_pc_q;
    fe_state_e   state_q;
    logic [2:0]  sq_cnt;

    logic        is_j_s;
    logic        is_jr_s;
    logic        is_trap_s;
    logic        live_s;
    logic        hold_s;
    logic        valid_d_s;
    fe_state_e   state_d_s;
    logic [2:0]  sq_cnt_d_s;

    fe_branch_decode #(
        .OP_J    (OP_J),
        .OP_JR   (OP_JR),
        .OP_TRAP (OP_TRAP)
    ) u_decode (
        .isn     (isn_q),
        .n_pc    (n_pc_q),
        .is_j    (is_j_s),
        .is_jr   (is_jr_s),
        .is_trap (is_trap_s),
        .jmp_i   (jmp_i)
    );

    assign jmp_r  = rs_data;
    assign de_isn = isn_q;
    assign de_pc  = n_pc_q - 32'd4;

    // Stall, redirect priority, downstream valid and next-state selection
    always_comb begin
        ctr        = CTR_RUN;
        jmp_type   = JT_SEQ;
        irq_ack    = 1'b0;
        live_s     = valid_q & ~rst & (state_q == ST_RUN);
        de_valid   = live_s;
        hold_s     = 1'b0;
        valid_d_s  = valid_q;
        state_d_s  = state_q;
        sq_cnt_d_s = sq_cnt;
        if (rst) begin
            de_valid = 1'b0;
        end else begin
            hold_s = valid_q & ((live_s & ~de_ready) | (is_jr_s & rs_busy));
            if (hold_s) begin
                ctr = CTR_STALL;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        valid_d_s = 1'b1;
                        if (valid_q) begin
                            // Any redirect discards the capture taken this edge
                            if (irq_req) begin
                                jmp_type = JT_INT;
                                irq_ack  = 1'b1;
                                de_valid = 1'b0;
                            end else if (is_trap_s) begin
                                jmp_type = JT_INT;
                            end else if (is_jr_s) begin
                                jmp_type = JT_REG;
                            end else if (is_j_s) begin
                                jmp_type = JT_IMM;
                            end else begin
                                jmp_type = JT_SEQ;
                            end
                            if (jmp_type != JT_SEQ) begin
                                valid_d_s  = 1'b0;
                                state_d_s  = ST_SQUASH;
                                sq_cnt_d_s = SQ_INIT;
                            end else begin
                                state_d_s  = ST_RUN;
                            end
                        end else begin
                            state_d_s = ST_RUN;
                        end
                    end
                    ST_SQUASH: begin
                        // Last squash slot hands over to the correct-path fetch
                        if (sq_cnt <= 3'd1) begin
                            valid_d_s  = 1'b1;
                            state_d_s  = ST_RUN;
                            sq_cnt_d_s = 3'd0;
                        end else begin
                            valid_d_s  = 1'b0;
                            sq_cnt_d_s = sq_cnt - 3'd1;
                        end
                    end
                    default: begin
                        valid_d_s  = 1'b0;
                        state_d_s  = ST_RUN;
                        sq_cnt_d_s = 3'd0;
                    end
                endcase
            end
        end
    end

    // FE/DE holding register and sequencer state; frozen while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            isn_q   <= 32'd0;
            n_pc_q  <= 32'd0;
            state_q <= ST_RUN;
            sq_cnt  <= 3'd0;
        end else if (!hold_s) begin
            valid_q <= valid_d_s;
            isn_q   <= isn;
            n_pc_q  <= n_pc;
            state_q <= state_d_s;
            sq_cnt  <= sq_cnt_d_s;
        end else begin
            valid_q <= valid_q;
            isn_q   <= isn_q;
            n_pc_q  <= n_pc_q;
            state_q <= state_q;
            sq_cnt  <= sq_cnt;
        end
    end

endmodule

// File: tb/tb_fe_redirect_ctl.sv
// Scoreboard bench for fe_redirect_ctl: directed fetch vectors push the
// expected downstream transfers and fetch-control events; a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_fe_redirect_ctl;
    import fe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] n_pc;
    logic [31:0] isn;
    logic [1:0]  ctr;
    logic [1:0]  jmp_type;
    logic [31:0] jmp_r;
    logic [31:0] jmp_i;
    logic [31:0] rs_data;
    logic        rs_busy;
    logic        irq_req;
    logic        irq_ack;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_isn;
    logic [31:0] de_pc;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [31:0] isn;
        logic [31:0] pc;
    } xfer_t;

    typedef struct {
        logic [1:0]  ctr;
        logic [1:0]  jt;
        logic [31:0] val;
        logic        ack;
    } ctl_t;

    xfer_t xq[$];
    ctl_t  cq[$];

    localparam logic [31:0] I_J1   = 32'h0800_0003;  // J +3 words
    localparam logic [31:0] I_J2   = 32'h0BFF_FFFE;  // J -2 words
    localparam logic [31:0] I_JR   = 32'h0C40_0000;  // JR
    localparam logic [31:0] I_J3   = 32'h0800_0001;
    localparam logic [31:0] I_J4   = 32'h0800_0005;
    localparam logic [31:0] I_J5   = 32'h0800_0002;
    localparam logic [31:0] I_TRAP = 32'hFC00_0000;

    fe_redirect_ctl #(.SQUASH_CYCLES(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .n_pc     (n_pc),
        .isn      (isn),
        .ctr      (ctr),
        .jmp_type (jmp_type),
        .jmp_r    (jmp_r),
        .jmp_i    (jmp_i),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .irq_req  (irq_req),
        .irq_ack  (irq_ack),
        .de_valid (de_valid),
        .de_ready (de_ready),
        .de_isn   (de_isn),
        .de_pc    (de_pc)
    );

    always #5 clk = ~clk;

    task automatic push_x(input logic [31:0] i, input logic [31:0] p);
        xfer_t e;
        e.isn = i;
        e.pc  = p;
        xq.push_back(e);
    endtask

    task automatic push_c(input logic [1:0] c, input logic [1:0] t,
                          input logic [31:0] v, input logic a);
        ctl_t e;
        e.ctr = c;
        e.jt  = t;
        e.val = v;
        e.ack = a;
        cq.push_back(e);
    endtask

    task automatic step(input logic [31:0] i, input logic [31:0] p);
        isn  = i;
        n_pc = p;
        @(posedge clk);
        #1;
    endtask

    // Expect no fetch control and no downstream activity for one cycle
    task automatic check_quiet(input string name);
        @(negedge clk);
        checks++;
        if ({ctr, jmp_type, de_valid, irq_ack} !== 6'b0) begin
            failures++;
            $display("FAIL %s got ctr=%b jt=%b de_valid=%b irq_ack=%b required all zero",
                     name, ctr, jmp_type, de_valid, irq_ack);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: transfers and fetch-control events against the scoreboard
    always @(negedge clk) begin
        xfer_t       xe;
        ctl_t        ce;
        logic [31:0] act;
        if (mon_en) begin
            if (de_valid && de_ready) begin
                checks++;
                if (xq.size() == 0) begin
                    failures++;
                    $display("FAIL xfer_unexpected got isn=%h pc=%h required none", de_isn, de_pc);
                end else begin
                    xe = xq.pop_front();
                    if (de_isn !== xe.isn || de_pc !== xe.pc) begin
                        failures++;
                        $display("FAIL xfer got isn=%h pc=%h required isn=%h pc=%h",
                                 de_isn, de_pc, xe.isn, xe.pc);
                    end
                end
            end
            if (ctr != 2'b00 || jmp_type != 2'b00 || irq_ack) begin
                checks++;
                if (cq.size() == 0) begin
                    failures++;
                    $display("FAIL ctl_unexpected got ctr=%b jt=%b ack=%b required none",
                             ctr, jmp_type, irq_ack);
                end else begin
                    ce = cq.pop_front();
                    case (ce.jt)
                        JT_REG:  act = jmp_r;
                        JT_IMM:  act = jmp_i;
                        JT_INT:  act = {31'd0, de_valid};
                        default: act = de_isn;
                    endcase
                    if (ctr !== ce.ctr || jmp_type !== ce.jt || irq_ack !== ce.ack || act !== ce.val) begin
                        failures++;
                        $display("FAIL ctl got ctr=%b jt=%b ack=%b val=%h required ctr=%b jt=%b ack=%b val=%h",
                                 ctr, jmp_type, irq_ack, act, ce.ctr, ce.jt, ce.ack, ce.val);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; isn = 32'd0; n_pc = 32'd0; rs_data = 32'd0;
        rs_busy = 1'b0; irq_req = 1'b0; de_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (de_isn !== 32'd0 || de_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL reset_regs got isn=%h pc=%h required isn=00000000 pc=fffffffc", de_isn, de_pc);
        end
        check_quiet("reset_outputs");

        rst = 1'b0; mon_en = 1'b1;
        // Straight-line
        step(32'h11, 32'h4);
        push_x(32'h11, 32'h0);       step(32'h12, 32'h8);
        push_x(32'h12, 32'h4);       step(32'h13, 32'hC);
        push_x(32'h13, 32'h8);       step(I_J1, 32'h104);
        // J forward: one wrong-path capture squashed
        push_c(CTR_RUN, JT_IMM, 32'h110, 1'b0);
        push_x(I_J1, 32'h100);       step(32'h99, 32'h108);
        step(32'h21, 32'h114);
        push_x(32'h21, 32'h110);     step(I_J2, 32'h4);
        // J backward with wrap
        push_c(CTR_RUN, JT_IMM, 32'hFFFF_FFFC, 1'b0);
        push_x(I_J2, 32'h0);         step(32'h98, 32'h8);
        step(I_JR, 32'h200);
        // JR waiting on its source register
        rs_busy = 1'b1; rs_data = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            push_c(CTR_STALL, JT_SEQ, I_JR, 1'b0);
            push_x(I_JR, 32'h1FC);
            step(32'h31, 32'h204);
        end
        rs_busy = 1'b0;
        push_c(CTR_RUN, JT_REG, 32'h2000, 1'b0);
        push_x(I_JR, 32'h1FC);       step(32'h31, 32'h204);
        step(32'h41, 32'h2004);
        push_x(32'h41, 32'h2000);    step(I_J3, 32'h304);
        // Backpressure on a J: no redirect until accepted
        de_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_c(CTR_STALL, JT_SEQ, I_J3, 1'b0);
            step(32'h51, 32'h308);
        end
        de_ready = 1'b1;
        push_c(CTR_RUN, JT_IMM, 32'h308, 1'b0);
        push_x(I_J3, 32'h300);       step(32'h51, 32'h308);
        step(I_J4, 32'h30C);
        // Interrupt beats the held J and drops it
        irq_req = 1'b1;
        push_c(CTR_RUN, JT_INT, 32'h0, 1'b1);
        step(32'h61, 32'h310);
        irq_req = 1'b0;
        step(32'h71, 32'hC000_0004);
        push_x(32'h71, 32'hC000_0000); step(I_TRAP, 32'hC000_0008);
        // Trap redirects but still goes downstream
        push_c(CTR_RUN, JT_INT, 32'h1, 1'b0);
        push_x(I_TRAP, 32'hC000_0004); step(32'h81, 32'hC000_000C);
        step(32'h82, 32'h100);
        push_x(32'h82, 32'hFC);      step(I_J5, 32'h404);
        push_c(CTR_RUN, JT_IMM, 32'h40C, 1'b0);
        push_x(I_J5, 32'h400);       step(32'h91, 32'h408);
        // Reset in the middle of a squash, with an irq pending
        rst = 1'b1; irq_req = 1'b1; isn = 32'h92; n_pc = 32'h40C;
        check_quiet("reset_in_squash");
        rst = 1'b0; irq_req = 1'b0;
        step(32'hA1, 32'h500);
        push_x(32'hA1, 32'h4FC);     step(32'hA2, 32'h504);
        push_x(32'hA2, 32'h500);     step(32'h0, 32'h0);
        // Reset gates outputs even with a valid instruction held
        rst = 1'b1;
        check_quiet("reset_gates_valid");
        check_quiet("reset_idle");

        checks++;
        if (xq.size() != 0) begin
            failures++;
            $display("FAIL xfer_missing got pending=%0d required 0", xq.size());
        end
        checks++;
        if (cq.size() != 0) begin
            failures++;
            $display("FAIL ctl_missing got pending=%0d required 0", cq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
